// File: rtl/ssp_rx_pkg.sv
// ---------------------------------------------------------------------------
// ssp_rx_pkg : shared types and defaults for the SSP receive read scheduler
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ssp_rx_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LVL_W_DEF = lvl_width(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ssp_rx_rr_arb.sv
// ---------------------------------------------------------------------------
// ssp_rx_rr_arb : 2-way round-robin arbiter (bit 0 = CPU, bit 1 = DMA)
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ssp_rx_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] win_o,
  output logic       last_o
);

  // last_q = 1 means DMA was served last, so the CPU leads after reset
  logic last_q;

  always_comb begin
    win_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = last_q ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (adv_i) begin
      last_q <= win_o[1];
    end
  end

  assign last_o = last_q;

endmodule

`default_nettype wire

// File: rtl/ssp_rx_arbiter.sv
// ---------------------------------------------------------------------------
// ssp_rx_arbiter : CPU/DMA read scheduler for the SSP receive FIFO with
//                  shadow occupancy; optional timeout via SSP_RX_TIMEOUT_EN
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ssp_rx_arbiter
  import ssp_rx_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                        PCLK,
  input  logic                        CLEAR,
  input  logic                        FIFO_WE,
  output logic                        FIFO_PSEL,
  output logic                        FIFO_PWRITE,
  input  logic [DW-1:0]               FIFO_PRDATA,
  input  logic                        CPU_REQ,
  output logic                        CPU_GNT,
  output logic [DW-1:0]               CPU_RDATA,
  output logic                        CPU_RVALID,
  input  logic                        DMA_REQ,
  output logic                        DMA_GNT,
  output logic [DW-1:0]               DMA_RDATA,
  output logic                        DMA_RVALID,
  output logic [lvl_width(DEPTH)-1:0] LEVEL,
  output logic                        EMPTY,
  output logic                        RXTO_INTR
);

  localparam int LW = lvl_width(DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  state_e        state_q;
  logic          psel_q;
  logic          cpu_gnt_q, dma_gnt_q;
  logic          cpu_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic [LW-1:0] level_q, level_d;
  logic          empty;
  logic          start;
  logic [1:0]    arb_win;
  logic          arb_last;

  assign empty = (level_q == '0);
  assign start = (state_q == ST_IDLE) && (CPU_REQ || DMA_REQ) && !empty;

  ssp_rx_rr_arb u_arb (
    .clk    (PCLK),
    .rst    (CLEAR),
    .req_i  ({DMA_REQ, CPU_REQ}),
    .adv_i  (start),
    .win_o  (arb_win),
    .last_o (arb_last)
  );

  always_comb begin
    level_d = level_q;
    if (FIFO_WE && !psel_q && (level_q != LVL_MAX)) begin
      level_d = level_q + LVL_ONE;
    end else if (psel_q && !FIFO_WE && (level_q != '0)) begin
      level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // The pointer advances on entering RD, so in CAP it names the current winner
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q      <= ST_IDLE;
      psel_q       <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      psel_q       <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RD;
            psel_q    <= 1'b1;
            cpu_gnt_q <= arb_win[0];
            dma_gnt_q <= arb_win[1];
          end
        end
        ST_RD: begin
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          state_q <= ST_IDLE;
          if (arb_last) begin
            dma_rdata_q  <= FIFO_PRDATA;
            dma_rvalid_q <= 1'b1;
          end else begin
            cpu_rdata_q  <= FIFO_PRDATA;
            cpu_rvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SSP_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] to_cnt_q;
  logic          rxto_q;

  // Counter saturates at its terminal value so it cannot wrap while idle
  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      to_cnt_q <= '0;
      rxto_q   <= 1'b0;
    end else begin
      if (FIFO_WE || psel_q || empty) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_LAST) begin
        to_cnt_q <= to_cnt_q + TO_ONE;
      end
      if (psel_q || empty) begin
        rxto_q <= 1'b0;
      end else if (to_cnt_q == TO_LAST) begin
        rxto_q <= 1'b1;
      end
    end
  end

  assign RXTO_INTR = rxto_q;
`else
  assign RXTO_INTR = 1'b0;
`endif

  assign FIFO_PSEL   = psel_q;
  assign FIFO_PWRITE = 1'b0;
  assign CPU_GNT     = cpu_gnt_q;
  assign DMA_GNT     = dma_gnt_q;
  assign CPU_RVALID  = cpu_rvalid_q;
  assign DMA_RVALID  = dma_rvalid_q;
  assign CPU_RDATA   = cpu_rdata_q;
  assign DMA_RDATA   = dma_rdata_q;
  assign LEVEL       = level_q;
  assign EMPTY       = empty;

endmodule

`default_nettype wire

// File: tb/tb_ssp_rx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ssp_rx_arbiter : directed bench for ssp_rx_arbiter with a FIFO model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ssp_rx_arbiter;

  logic       PCLK;
  logic       CLEAR;
  logic       FIFO_WE;
  logic       FIFO_PSEL;
  logic       FIFO_PWRITE;
  logic [7:0] FIFO_PRDATA;
  logic       CPU_REQ, CPU_GNT, CPU_RVALID;
  logic [7:0] CPU_RDATA;
  logic       DMA_REQ, DMA_GNT, DMA_RVALID;
  logic [7:0] DMA_RDATA;
  logic [2:0] LEVEL;
  logic       EMPTY;
  logic       RXTO_INTR;
  logic [7:0] wdata;

  int n_chk = 0;
  int n_err = 0;

  ssp_rx_arbiter #(.DW(8), .DEPTH(4), .TIMEOUT(32)) dut (
    .PCLK        (PCLK),
    .CLEAR       (CLEAR),
    .FIFO_WE     (FIFO_WE),
    .FIFO_PSEL   (FIFO_PSEL),
    .FIFO_PWRITE (FIFO_PWRITE),
    .FIFO_PRDATA (FIFO_PRDATA),
    .CPU_REQ     (CPU_REQ),
    .CPU_GNT     (CPU_GNT),
    .CPU_RDATA   (CPU_RDATA),
    .CPU_RVALID  (CPU_RVALID),
    .DMA_REQ     (DMA_REQ),
    .DMA_GNT     (DMA_GNT),
    .DMA_RDATA   (DMA_RDATA),
    .DMA_RVALID  (DMA_RVALID),
    .LEVEL       (LEVEL),
    .EMPTY       (EMPTY),
    .RXTO_INTR   (RXTO_INTR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Receive FIFO model with registered read data
  logic [7:0] fifo_q[$];
  always @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      fifo_q.delete();
      FIFO_PRDATA <= 8'h00;
    end else begin
      if (FIFO_PSEL && (fifo_q.size() > 0)) FIFO_PRDATA <= fifo_q.pop_front();
      if (FIFO_WE) fifo_q.push_back(wdata);
    end
  end

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       cr, dr;
    logic       psel, cg, dg, crv, drv;
    logic [7:0] crd, drd;
    logic [2:0] lvl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [7:0] wd,
                              input logic cr, input logic dr,
                              input logic psel, input logic cg, input logic dg,
                              input logic crv, input logic drv,
                              input logic [7:0] crd, input logic [7:0] drd,
                              input logic [2:0] lvl);
    vec_t v;
    v.we = we; v.wd = wd; v.cr = cr; v.dr = dr;
    v.psel = psel; v.cg = cg; v.dg = dg; v.crv = crv; v.drv = drv;
    v.crd = crd; v.drd = drd; v.lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_inputs();
    FIFO_WE = 1'b0; wdata = 8'h00; CPU_REQ = 1'b0; DMA_REQ = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    CLEAR = 1'b1;
    step();
    step();
    CLEAR = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " psel"},   {31'd0, FIFO_PSEL}, 32'd0);
    chk({tag, " pwrite"}, {31'd0, FIFO_PWRITE}, 32'd0);
    chk({tag, " gnt"},    {30'd0, DMA_GNT, CPU_GNT}, 32'd0);
    chk({tag, " rvalid"}, {30'd0, DMA_RVALID, CPU_RVALID}, 32'd0);
    chk({tag, " rdata"},  {16'd0, DMA_RDATA, CPU_RDATA}, 32'd0);
    chk({tag, " level"},  {29'd0, LEVEL}, 32'd0);
    chk({tag, " empty"},  {31'd0, EMPTY}, 32'd1);
    chk({tag, " rxto"},   {31'd0, RXTO_INTR}, 32'd0);
  endtask

  int first_to;
  int psel_seen;
  int rv_seen;

  initial begin
    // Fill four words, both request (CPU, DMA, CPU, DMA), then CPU-only,
    // DMA-only with a write coinciding with the read strobe, then fill to full
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd2));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd3));
    vecs.push_back(mk(1, 8'h44, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd4));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 3'd4));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd3));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h11, 8'h00, 3'd3));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'h11, 8'h00, 3'd3));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h11, 8'h00, 3'd2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 8'h11, 8'h22, 3'd2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 0, 0, 0, 8'h11, 8'h22, 3'd2));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h11, 8'h22, 3'd1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 8'h33, 8'h22, 3'd1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 1, 0, 0, 8'h33, 8'h22, 3'd1));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h33, 8'h22, 3'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 8'h33, 8'h44, 3'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h33, 8'h44, 3'd0));
    vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h33, 8'h44, 3'd0));
    vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 8'h33, 8'h44, 3'd1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 0, 0, 8'h33, 8'h44, 3'd1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h33, 8'h44, 3'd0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 8'hA5, 8'h44, 3'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h44, 3'd0));
    vecs.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h44, 3'd1));
    vecs.push_back(mk(1, 8'h66, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h44, 3'd2));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 1, 0, 0, 8'hA5, 8'h44, 3'd2));
    vecs.push_back(mk(1, 8'h77, 0, 1, 0, 0, 0, 0, 0, 8'hA5, 8'h44, 3'd2));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'hA5, 8'h55, 3'd2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h55, 3'd2));
    vecs.push_back(mk(1, 8'h88, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h55, 3'd3));
    vecs.push_back(mk(1, 8'h99, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h55, 3'd4));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h55, 3'd4));

    CLEAR = 1'b0;
    idle_inputs();
    #2;
    CLEAR = 1'b1;
    #1;
    chk_reset_state("reset");
    step();
    step();
    CLEAR = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      FIFO_WE = vecs[i].we;
      wdata   = vecs[i].wd;
      CPU_REQ = vecs[i].cr;
      DMA_REQ = vecs[i].dr;
      step();
      chk($sformatf("v%0d psel", i),   {31'd0, FIFO_PSEL}, {31'd0, vecs[i].psel});
      chk($sformatf("v%0d gnt", i),    {30'd0, DMA_GNT, CPU_GNT}, {30'd0, vecs[i].dg, vecs[i].cg});
      chk($sformatf("v%0d rvalid", i), {30'd0, DMA_RVALID, CPU_RVALID}, {30'd0, vecs[i].drv, vecs[i].crv});
      chk($sformatf("v%0d cpu_rdata", i), {24'd0, CPU_RDATA}, {24'd0, vecs[i].crd});
      chk($sformatf("v%0d dma_rdata", i), {24'd0, DMA_RDATA}, {24'd0, vecs[i].drd});
      chk($sformatf("v%0d level", i),  {29'd0, LEVEL}, {29'd0, vecs[i].lvl});
      chk($sformatf("v%0d empty", i),  {31'd0, EMPTY}, {31'd0, (vecs[i].lvl == 3'd0)});
      chk($sformatf("v%0d pwrite", i), {31'd0, FIFO_PWRITE}, 32'd0);
    end

    // Request while empty, then minimum write-to-grant latency
    do_reset();
    CPU_REQ = 1'b1;
    psel_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (FIFO_PSEL) psel_seen++;
    end
    chk("empty_no_psel", psel_seen, 0);
    FIFO_WE = 1'b1; wdata = 8'hC3;
    step();
    FIFO_WE = 1'b0;
    chk("wr_gnt_t1", {31'd0, CPU_GNT}, 32'd0);
    step();
    chk("wr_gnt_t2", {30'd0, DMA_GNT, CPU_GNT}, 32'd1);
    step();
    step();
    chk("wr_rvalid", {31'd0, CPU_RVALID}, 32'd1);
    chk("wr_rdata", {24'd0, CPU_RDATA}, 32'h0000_00C3);
    CPU_REQ = 1'b0;
    step();

    // CLEAR asserted while in CAP drops the read
    FIFO_WE = 1'b1; wdata = 8'h3C;
    step();
    FIFO_WE = 1'b0; CPU_REQ = 1'b1;
    step();
    chk("clr_rd_psel", {31'd0, FIFO_PSEL}, 32'd1);
    step();
    #2;
    CLEAR = 1'b1;
    #1;
    chk_reset_state("clr_cap");
    CPU_REQ = 1'b0;
    #2;
    CLEAR = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (CPU_RVALID || DMA_RVALID) rv_seen++;
    end
    chk("clr_no_rvalid", rv_seen, 0);
    chk("clr_level", {29'd0, LEVEL}, 32'd0);

    // Receive timeout after a single unread word
    do_reset();
    FIFO_WE = 1'b1; wdata = 8'h5A;
    step();
    FIFO_WE = 1'b0;
    first_to = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (RXTO_INTR && (first_to == 0)) first_to = i;
    end
`ifdef SSP_RX_TIMEOUT_EN
    chk("rxto_delay", first_to, 32);
`else
    chk("rxto_off", first_to, 0);
`endif
    CPU_REQ = 1'b1;
    step();
`ifdef SSP_RX_TIMEOUT_EN
    chk("rxto_held_rd", {31'd0, RXTO_INTR}, 32'd1);
`endif
    step();
    chk("rxto_cleared", {31'd0, RXTO_INTR}, 32'd0);
    step();
    chk("rxto_rdata", {24'd0, CPU_RDATA}, 32'h0000_005A);
    chk("rxto_rvalid", {31'd0, CPU_RVALID}, 32'd1);
    CPU_REQ = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssp_rx_arbiter.md
# ssp_rx_arbiter

Read scheduler for the SSP receive FIFO: shares the FIFO's single read port between a CPU requester and a DMA requester using round-robin arbitration. It issues the FIFO read strobes, captures the FIFO's registered read data, and returns it to the granted requester. The FIFO exports no empty flag, so the block keeps a shadow occupancy count. It also raises a receive-timeout interrupt when data sits unread. It sits between the receive FIFO and the APB/DMA side of the SSP.

## Interface
Parameters:
- DW, 8, data width; must match the FIFO word.
- DEPTH, 4, FIFO depth in words.
- TIMEOUT, 32, idle cycles with unread data before RXTO_INTR is raised.

Ports:
- PCLK  in  1  single clock; all logic on its rising edge.
- CLEAR  in  1  reset, asynchronous, active-high.
- FIFO_WE  in  1  copy of the FIFO's accepted-write strobe (RECV && VALID).
- FIFO_PSEL  out  1  read strobe to the FIFO's PSEL.
- FIFO_PWRITE  out  1  drives the FIFO's PWRITE; constant 0.
- FIFO_PRDATA  in  DW  the FIFO's registered read data.
- CPU_REQ  in  1  CPU read request; level-sensitive, held until CPU_RVALID.
- CPU_GNT  out  1  one-cycle pulse: the CPU has won a read.
- CPU_RDATA  out  DW  returned data; holds its value until the next CPU read.
- CPU_RVALID  out  1  one-cycle pulse: CPU_RDATA is valid.
- DMA_REQ, DMA_GNT, DMA_RDATA, DMA_RVALID: same as the CPU ports, for DMA.
- LEVEL  out  $clog2(DEPTH)+1  shadow occupancy count.
- EMPTY  out  1  LEVEL == 0.
- RXTO_INTR  out  1  receive-timeout interrupt; sticky.

## Operation
- Shadow count LEVEL:
  - +1 on a cycle with FIFO_WE only.
  - −1 on a cycle with FIFO_PSEL only.
  - Unchanged when both occur in the same cycle.
  - Never exceeds DEPTH, because the FIFO refuses writes when full.
  - Never decrements at 0, because no strobe is issued while EMPTY.
- State machine, three states, one-hot or encoded:
  - IDLE: if (CPU_REQ || DMA_REQ) && !EMPTY, pick a winner and go to RD. Otherwise stay.
  - RD: FIFO_PSEL=1 and the winner's GNT=1 for exactly this cycle. Always go to CAP.
  - CAP: FIFO_PRDATA is now valid; load it into the winner's RDATA register. Always go to IDLE.
- RVALID is registered and pulses in the IDLE cycle that follows CAP. Arbitration runs in that same cycle.
- Arbitration:
  - A single requester wins.
  - If both request, the requester not served last wins.
  - After reset the CPU has priority.
  - The last-served pointer updates on entering RD.
- A request that drops during RD or CAP does not cancel the read. The data is still delivered with RVALID.
- The losing requester's outputs stay 0 and its RDATA keeps its value.

## Timing
- Reset values: FIFO_PSEL=0, FIFO_PWRITE=0, both GNT=0, both RVALID=0, both RDATA=0, LEVEL=0, EMPTY=1, RXTO_INTR=0, state IDLE, priority CPU.
- Latency: a request seen in IDLE at cycle t gives GNT and FIFO_PSEL at t+1, capture at t+2, RVALID at t+3.
- Sustained throughput: one word every 3 cycles.
- A FIFO_WE arriving in the same cycle the block sees EMPTY is not visible to arbitration until the next cycle. Minimum write-to-grant latency is 2 cycles.
- Reset mid-operation: CLEAR drops any in-flight read with no RVALID. The system drives the FIFO's CLEAR_B as the inverse of CLEAR, so both sides empty together.
- Wrap-around: LEVEL has no wrap. The FIFO pointers wrap internally, which is invisible here.

## Configuration
- SSP_RX_TIMEOUT_EN defined:
  - A counter runs while LEVEL>0 and there is neither FIFO_WE nor FIFO_PSEL; either event clears it.
  - When the count reaches TIMEOUT−1, RXTO_INTR sets on the next edge.
  - RXTO_INTR clears on the next FIFO_PSEL or when LEVEL becomes 0.
- Not defined: RXTO_INTR is tied to 0, the counter is not built, and TIMEOUT is ignored.

## Structure
- Package ssp_rx_pkg holds:
  - the state enum (IDLE, RD, CAP);
  - DW and DEPTH defaults;
  - the LEVEL width constant.
- Sub-module ssp_rx_rr_arb is the 2-way round-robin arbiter: inputs req[1:0] and an advance strobe, outputs a one-hot winner and the last-served pointer.

## Test plan
- CPU only: push 0xA5 (LEVEL=1), hold CPU_REQ → CPU_GNT at +1, CPU_RVALID at +3 with CPU_RDATA=0xA5, LEVEL=0, EMPTY=1.
- Both requesting, FIFO holds 0x11, 0x22, 0x33, 0x44 → reads go to CPU, DMA, CPU, DMA in that order with those values, 3 cycles apart. No strobe after LEVEL=0.
- Request while empty: CPU_REQ high for 10 cycles with no writes → FIFO_PSEL never asserts. A write then yields CPU_GNT 2 cycles later.
- Simultaneous FIFO_WE and FIFO_PSEL at LEVEL=2 → LEVEL stays 2. Filling to 4 with no reads keeps LEVEL=4.
- CLEAR pulsed during CAP → all outputs return to reset values immediately and RVALID does not pulse.
- SSP_RX_TIMEOUT_EN with TIMEOUT=32: one write and no requests → RXTO_INTR rises 32 cycles after the write. A CPU read clears it. Without the macro, RXTO_INTR stays 0.
